pc_fetch_ctrl: RTL and testbench

Fetch-stage sequencer for the pipelined MIPS core's program counter. Drives the PC register's enable and redirect inputs and the IF/ID register's enable and flush. Handles post-reset boot delay, instruction-memory wait states, load-use stalls, decode-stage jump/branch redirects and halt. A redirect that arrives while instruction memory is busy is held internally until the fetch completes.

---
 rtl/pc_fetch_ctrl.sv | 137 +++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: boot delay, imem wait states, load-use stalls, redirects and halt.
// Optional FETCH_PERF_EN adds saturating stall/redirect performance counters.
module pc_fetch_ctrl #(
  parameter int BOOT_DELAY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_ready,
  input  logic        hazard_stall,
  input  logic        jbr_d,
  input  logic [31:0] npc_d,
  input  logic        halt_d,
  output logic        imem_req,
  output logic        pc_en,
  output logic        pc_redirect,
  output logic [31:0] npc_out,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_redir_cnt
`endif
);

  localparam int CW        = (BOOT_DELAY > 0) ? $clog2(BOOT_DELAY + 1) : 1;
  localparam int BOOT_LAST = (BOOT_DELAY > 0) ? BOOT_DELAY - 1 : 0;

  typedef enum logic [1:0] {BOOT, FETCH, REDIR, HALT} state_t;

  state_t      state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic [31:0] tgt_reg, tgt_next;

  // With no boot delay the BOOT state would still cost one cycle, so reset lands in FETCH.
  localparam state_t RESET_STATE = (BOOT_DELAY == 0) ? FETCH : BOOT;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= RESET_STATE;
      cnt_reg   <= '0;
      tgt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      tgt_reg   <= tgt_next;
      if (state_reg == BOOT)
        cnt_reg <= cnt_reg + CW'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    tgt_next   = tgt_reg;
    case (state_reg)
      BOOT:  if (cnt_reg == CW'(BOOT_LAST)) state_next = FETCH;
      FETCH: begin
        if (hazard_stall) begin
          state_next = FETCH;
        end else if (halt_d) begin
          state_next = HALT;
        end else if (jbr_d && !imem_ready) begin
          state_next = REDIR;
          tgt_next   = npc_d;
        end
      end
      REDIR: if (imem_ready && !hazard_stall) state_next = FETCH;
      HALT:  state_next = HALT;
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    pc_en       = 1'b0;
    pc_redirect = 1'b0;
    npc_out     = npc_d;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b1;
    halted      = 1'b0;
    // While rst_n is low the outputs already show the idle boot values.
    if (rst_n) begin
      case (state_reg)
        FETCH: begin
          imem_req = 1'b1;
          if (hazard_stall) begin
            ifid_en    = 1'b0;
            ifid_flush = 1'b0;
          end else if (halt_d) begin
            ifid_flush = 1'b1;
          end else if (jbr_d && imem_ready) begin
            pc_en       = 1'b1;
            pc_redirect = 1'b1;
            ifid_flush  = 1'b0;
          end else if (imem_ready && !jbr_d) begin
            pc_en      = 1'b1;
            ifid_flush = 1'b0;
          end
        end
        REDIR: begin
          imem_req    = 1'b1;
          pc_redirect = 1'b1;
          npc_out     = tgt_reg;
          if (imem_ready && !hazard_stall) begin
            pc_en      = 1'b1;
            ifid_flush = 1'b0;
          end
        end
        HALT:    halted = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_reg, perf_redir_reg;
  logic        active;

  assign active = rst_n && (state_reg == FETCH || state_reg == REDIR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_reg <= '0;
      perf_redir_reg <= '0;
    end else begin
      if (active && !pc_en && perf_stall_reg != 32'hFFFF_FFFF)
        perf_stall_reg <= perf_stall_reg + 32'd1;
      if (active && pc_en && pc_redirect && perf_redir_reg != 32'hFFFF_FFFF)
        perf_redir_reg <= perf_redir_reg + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_reg;
  assign perf_redir_cnt = perf_redir_reg;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: directed test-plan sequence then random traffic against a behavioural model.
module tb_pc_fetch_ctrl;
  localparam int BD = 4;

  logic        clk = 1'b0;
  logic        rst_n, imem_ready, hazard_stall, jbr_d, halt_d;
  logic [31:0] npc_d;
  logic        imem_req, pc_en, pc_redirect, ifid_en, ifid_flush, halted;
  logic [31:0] npc_out;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cnt, perf_redir_cnt;
`endif

  pc_fetch_ctrl #(.BOOT_DELAY(BD)) dut (
    .clk(clk), .rst_n(rst_n), .imem_ready(imem_ready), .hazard_stall(hazard_stall),
    .jbr_d(jbr_d), .npc_d(npc_d), .halt_d(halt_d), .imem_req(imem_req), .pc_en(pc_en),
    .pc_redirect(pc_redirect), .npc_out(npc_out), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .halted(halted)
`ifdef FETCH_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_redir_cnt(perf_redir_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [37:0] outs;  // {imem_req,pc_en,pc_redirect,ifid_en,ifid_flush,halted,npc_out}
    logic [31:0] pstall;
    logic [31:0] predir;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Behavioural model: what phase the fetch stage is in, expressed as plain counters/flags.
  int          boot_left = BD;
  bit          m_halted  = 0;
  bit          pend      = 0;
  logic [31:0] m_tgt     = '0;
  logic [31:0] m_pstall  = '0;
  logic [31:0] m_predir  = '0;

  task automatic drive(input bit r, input bit rdy, input bit stl, input bit j,
                       input logic [31:0] npc, input bit h);
    bit          req, pe, pr, ie, fl, ha, active;
    logic [31:0] no;
    exp_t        e;
    @(posedge clk);
    #1;
    rst_n = r; imem_ready = rdy; hazard_stall = stl; jbr_d = j; npc_d = npc; halt_d = h;
    req = 0; pe = 0; pr = 0; ie = 1; fl = 1; ha = 0; no = npc; active = 0;
    e.pstall = m_pstall;
    e.predir = m_predir;
    if (!r) begin
      boot_left = BD; m_halted = 0; pend = 0; m_tgt = '0;
      m_pstall = '0; m_predir = '0;
    end else if (m_halted) begin
      ha = 1;
    end else if (boot_left > 0) begin
      boot_left--;
    end else if (pend) begin
      active = 1; req = 1; pr = 1; no = m_tgt;
      if (rdy && !stl) begin pe = 1; fl = 0; pend = 0; end
    end else begin
      active = 1; req = 1;
      if (stl) begin ie = 0; fl = 0; end
      else if (h) m_halted = 1;
      else if (j && rdy) begin pe = 1; pr = 1; fl = 0; end
      else if (j) begin pend = 1; m_tgt = npc; end
      else if (rdy) begin pe = 1; fl = 0; end
    end
    if (r && active && !pe && m_pstall != 32'hFFFF_FFFF) m_pstall++;
    if (r && active && pe && pr && m_predir != 32'hFFFF_FFFF) m_predir++;
    e.cyc  = cyc++;
    e.outs = {req, pe, pr, ie, fl, ha, no};
    exp_q.push_back(e);
  endtask

  // Monitor: sample combinational outputs mid-cycle and score against the queue.
  initial begin
    exp_t        e;
    logic [37:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {imem_req, pc_en, pc_redirect, ifid_en, ifid_flush, halted, npc_out};
        n_checks++;
        if (got !== e.outs) begin
          n_fail++;
          $display("FAIL cyc%0d outputs got=%h exp=%h", e.cyc, got, e.outs);
        end
`ifdef FETCH_PERF_EN
        n_checks++;
        if (perf_stall_cnt !== e.pstall || perf_redir_cnt !== e.predir) begin
          n_fail++;
          $display("FAIL cyc%0d perf got=%h/%h exp=%h/%h", e.cyc,
                   perf_stall_cnt, perf_redir_cnt, e.pstall, e.predir);
        end
`endif
      end
    end
  end

  initial begin
    int wait_cnt;
    rst_n = 0; imem_ready = 1; hazard_stall = 0; jbr_d = 0; halt_d = 0; npc_d = '0;
    // Reset then boot: 4 bubble cycles, then fetching.
    drive(0, 1, 0, 0, 32'h0, 0);
    drive(0, 1, 0, 0, 32'h0, 0);
    for (int i = 0; i < BD + 3; i++) drive(1, 1, 0, 0, 32'h0000_1000 + i, 0);
    // Redirect with imem ready.
    drive(1, 1, 0, 1, 32'h0000_3040, 0);
    // Redirect with imem busy for 3 cycles, then ready.
    drive(1, 0, 0, 1, 32'h0000_3100, 0);
    drive(1, 0, 0, 0, 32'h0000_0004, 0);
    drive(1, 0, 0, 1, 32'h0000_7777, 0);
    drive(1, 1, 0, 0, 32'h0000_0008, 0);
    drive(1, 1, 0, 0, 32'h0000_000c, 0);
    // Stall dominates jbr and halt; then halt.
    drive(1, 1, 1, 1, 32'h0000_5000, 1);
    drive(1, 1, 0, 1, 32'h0000_5000, 1);
    drive(1, 1, 0, 1, 32'h0000_5004, 0);
    // Reset while a redirect is pending; no stale redirect after boot.
    drive(0, 1, 0, 0, 32'h0, 0);
    for (int i = 0; i < BD; i++) drive(1, 1, 0, 0, 32'h0, 0);
    drive(1, 0, 0, 1, 32'h0000_3100, 0);
    drive(0, 1, 0, 0, 32'h0000_0020, 0);
    for (int i = 0; i < BD + 4; i++) drive(1, 1, 0, 0, 32'h0000_2000 + i, 0);
    // Random traffic.
    for (int i = 0; i < 3000; i++)
      drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 99) < 15), ($urandom_range(0, 4) == 0),
            $urandom, ($urandom_range(0, 99) < 2));
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain queue_left=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
